// File: rtl/oisc_bus_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// oisc_bus_pkg : shared bus region map, state encoding, address decode
// Rev 1.0
// ------------------------------------------------------------------
package oisc_bus_pkg;

  localparam logic [15:0] MEM_REGION_MASK = 16'hFC00;
  localparam logic [15:0] ALU_BASE        = 16'h8000;
  localparam int unsigned ALU_SPAN        = 8;
  localparam logic [15:0] ALU_MASK        = ~(16'(ALU_SPAN) - 16'd1);

  typedef enum logic [1:0] {REG_MEM, REG_ALU, REG_EXT} region_e;

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, CAPTURE, RESP} state_e;

  function automatic region_e decode_region(input logic [15:0] addr);
    if ((addr & MEM_REGION_MASK) == 16'h0000) begin
      return REG_MEM;
    end else if ((addr & ALU_MASK) == ALU_BASE) begin
      return REG_ALU;
    end else begin
      return REG_EXT;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/oisc_addr_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// oisc_addr_decode : 16-bit word address to bus region
// Rev 1.0
// ------------------------------------------------------------------
module oisc_addr_decode
  import oisc_bus_pkg::*;
(
  input  logic [15:0] addr,
  output region_e     region
);

  assign region = decode_region(addr);

endmodule
`default_nettype wire

// File: rtl/oisc_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// oisc_bus_arbiter : two-master round-robin arbiter and access sequencer
// Rev 1.0 | optional ext_ack timeout: OISC_ARB_TIMEOUT_EN
// ------------------------------------------------------------------
module oisc_bus_arbiter
  import oisc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MEM_AW         = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [15:0]       m0_addr,
  input  logic [15:0]       m0_wdata,
  output logic [15:0]       m0_rdata,
  output logic              m0_rdy,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [15:0]       m1_addr,
  input  logic [15:0]       m1_wdata,
  output logic [15:0]       m1_rdata,
  output logic              m1_rdy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              alu_en,
  output logic              alu_we,
  output logic [2:0]        alu_addr,
  output logic [15:0]       alu_wdata,
  input  logic [15:0]       alu_rdata,
  output logic              ext_req,
  output logic              ext_we,
  output logic [15:0]       ext_addr,
  output logic [15:0]       ext_wdata,
  input  logic [15:0]       ext_rdata,
  input  logic              ext_ack,
  output logic [1:0]        grant,
  output logic              err
);

  state_e              state_q, state_d;
  region_e             region_q, region_d;
  logic [1:0]          grant_q, grant_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic                m0_rdy_q, m0_rdy_d, m1_rdy_q, m1_rdy_d;
  logic [15:0]         m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;
  logic                alu_en_q, alu_en_d, alu_we_q, alu_we_d;
  logic [2:0]          alu_addr_q, alu_addr_d;
  logic [15:0]         alu_wdata_q, alu_wdata_d;
  logic                ext_req_q, ext_req_d, ext_we_q, ext_we_d;
  logic [15:0]         ext_addr_q, ext_addr_d, ext_wdata_q, ext_wdata_d;

  logic                pick_m1;
  logic                sel_we;
  logic [15:0]         sel_addr, sel_wdata;
  region_e             sel_region;
  logic                done;
  logic [15:0]         done_data;

`ifdef OISC_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                expired;
  // cnt_q holds the number of ext_req cycles already completed
  assign expired = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

  // last_q = 1 means m1 was served last, so m0 wins the next tie
  assign pick_m1   = m1_req & (~m0_req | ~last_q);
  assign sel_we    = pick_m1 ? m1_we    : m0_we;
  assign sel_addr  = pick_m1 ? m1_addr  : m0_addr;
  assign sel_wdata = pick_m1 ? m1_wdata : m0_wdata;

  oisc_addr_decode u_decode (
    .addr   (sel_addr),
    .region (sel_region)
  );

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    grant_d     = grant_q;
    last_d      = last_q;
    we_d        = we_q;
    m0_rdy_d    = 1'b0;
    m1_rdy_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    alu_en_d    = 1'b0;
    alu_we_d    = 1'b0;
    alu_addr_d  = alu_addr_q;
    alu_wdata_d = alu_wdata_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    done        = 1'b0;
    done_data   = 16'h0000;
`ifdef OISC_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          state_d  = ACCESS;
          grant_d  = pick_m1 ? 2'b10 : 2'b01;
          last_d   = pick_m1;
          we_d     = sel_we;
          region_d = sel_region;
          unique case (sel_region)
            REG_MEM: begin
              mem_en_d    = 1'b1;
              mem_we_d    = sel_we;
              mem_addr_d  = sel_addr[MEM_AW-1:0];
              mem_wdata_d = sel_wdata;
            end
            REG_ALU: begin
              alu_en_d    = 1'b1;
              alu_we_d    = sel_we;
              alu_addr_d  = sel_addr[2:0];
              alu_wdata_d = sel_wdata;
            end
            default: begin
              ext_req_d   = 1'b1;
              ext_we_d    = sel_we;
              ext_addr_d  = sel_addr;
              ext_wdata_d = sel_wdata;
            end
          endcase
        end
      end
      ACCESS: begin
        state_d = (region_q == REG_EXT) ? WAIT : CAPTURE;
`ifdef OISC_ARB_TIMEOUT_EN
        cnt_d   = CNT_W'(1);
`endif
      end
      WAIT: begin
        if (ext_ack) begin
          done      = 1'b1;
          done_data = we_q ? 16'h0000 : ext_rdata;
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
          state_d   = RESP;
        end
`ifdef OISC_ARB_TIMEOUT_EN
        else if (expired) begin
          done      = 1'b1;
          done_data = 16'hFFFF;
          err_d     = 1'b1;
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      CAPTURE: begin
        done      = 1'b1;
        done_data = we_q ? 16'h0000 :
                    (region_q == REG_ALU) ? alu_rdata : mem_rdata;
        state_d   = RESP;
      end
      RESP: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      if (grant_q[1]) begin
        m1_rdy_d   = 1'b1;
        m1_rdata_d = done_data;
      end else begin
        m0_rdy_d   = 1'b1;
        m0_rdata_d = done_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      region_q    <= REG_MEM;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      m0_rdy_q    <= 1'b0;
      m1_rdy_q    <= 1'b0;
      m0_rdata_q  <= 16'h0000;
      m1_rdata_q  <= 16'h0000;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'h0000;
      alu_en_q    <= 1'b0;
      alu_we_q    <= 1'b0;
      alu_addr_q  <= 3'd0;
      alu_wdata_q <= 16'h0000;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= 16'h0000;
      ext_wdata_q <= 16'h0000;
`ifdef OISC_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      we_q        <= we_d;
      m0_rdy_q    <= m0_rdy_d;
      m1_rdy_q    <= m1_rdy_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      alu_en_q    <= alu_en_d;
      alu_we_q    <= alu_we_d;
      alu_addr_q  <= alu_addr_d;
      alu_wdata_q <= alu_wdata_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
`ifdef OISC_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign m0_rdy    = m0_rdy_q;
  assign m1_rdy    = m1_rdy_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign alu_en    = alu_en_q;
  assign alu_we    = alu_we_q;
  assign alu_addr  = alu_addr_q;
  assign alu_wdata = alu_wdata_q;
  assign ext_req   = ext_req_q;
  assign ext_we    = ext_we_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign grant     = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_oisc_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// tb_oisc_bus_arbiter : directed scoreboard bench for the two-master arbiter
module tb_oisc_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [15:0] m0_rdata, m1_rdata;
  logic        m0_rdy, m1_rdy;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        alu_en, alu_we;
  logic [2:0]  alu_addr;
  logic [15:0] alu_wdata;
  logic [15:0] alu_rdata = '0;
  logic        ext_req, ext_we;
  logic [15:0] ext_addr, ext_wdata;
  logic [15:0] ext_rdata = '0;
  logic        ext_ack = 1'b0;
  logic [1:0]  grant;
  logic        err;

  always #5 clk = ~clk;

  oisc_bus_arbiter #(.TIMEOUT_CYCLES(8), .MEM_AW(10)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_rdy(m0_rdy),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_rdy(m1_rdy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .alu_en(alu_en), .alu_we(alu_we), .alu_addr(alu_addr), .alu_wdata(alu_wdata),
    .alu_rdata(alu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .grant(grant), .err(err)
  );

  // Target models: synchronous memory and a fixed-value ALU read port
  logic [15:0] mem [0:1023];
  logic [15:0] alu_val = 16'h0000;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
    if (alu_en && !alu_we) alu_rdata <= alu_val;
  end

  int mem_en_cnt = 0, alu_en_cnt = 0, multi_cnt = 0, consec_cnt = 0;
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (mem_en) mem_en_cnt++;
    if (alu_en) alu_en_cnt++;
    if ((int'(mem_en) + int'(alu_en) + int'(ext_req)) > 1) multi_cnt++;
    if ((mem_en || alu_en) && prev_strobe) consec_cnt++;
    prev_strobe = mem_en || alu_en;
  end

  typedef struct {
    logic        m;
    logic [15:0] data;
    logic        e;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic m, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_data,
                       input logic exp_err);
    exp_t e;
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
    e.m = m; e.data = exp_data; e.e = exp_err;
    sb.push_back(e);
  endtask

  // Waits for the next rdy, compares it against the scoreboard head, drops req
  task automatic wait_rdy(input int budget, output int lat);
    exp_t e;
    logic got;
    got = 1'b0;
    lat = -1;
    for (int i = 1; i <= budget && !got; i++) begin
      @(negedge clk);
      if (m0_rdy || m1_rdy) begin
        got = 1'b1;
        lat = i;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL sb_underflow observed=rdy expected=none");
        end else begin
          e = sb.pop_front();
          check("rdy_owner", {30'd0, m1_rdy, m0_rdy}, e.m ? 32'd2 : 32'd1);
          check("rdata", e.m ? m1_rdata : m0_rdata, {16'd0, e.data});
          check("err", {31'd0, err}, {31'd0, e.e});
          if (e.m) m1_req = 1'b0;
          else     m0_req = 1'b0;
        end
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $error("FAIL rdy_timeout observed=no_rdy expected=rdy_within_%0d", budget);
    end
  endtask

  initial begin
    int   lat;
    int   cnt;
    int   base;
    time  t0;

    // Reset held with m0 already requesting
    issue(1'b0, 1'b1, 16'h0010, 16'hAAAA, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_outputs", {31'd0, |{m0_rdata, m1_rdata, m0_rdy, m1_rdy, mem_en, mem_we,
          mem_addr, mem_wdata, alu_en, alu_we, alu_addr, alu_wdata, ext_req, ext_we,
          ext_addr, ext_wdata, grant, err}}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mem_en_c1", {31'd0, mem_en}, 32'd1);
    check("rst_grant_c1", {30'd0, grant}, 32'd1);
    wait_rdy(10, lat);
    check("rst_rdy_c3", lat, 32'd2);

    // m0 write then read back
    @(negedge clk);
    check("idle_grant", {30'd0, grant}, 32'd0);
    issue(1'b0, 1'b1, 16'h0005, 16'h1234, 16'h0000, 1'b0);
    @(negedge clk);
    check("wr_mem", {mem_en, mem_we, 4'd0, mem_addr, mem_wdata}, {2'b11, 4'd0, 10'd5, 16'h1234});
    wait_rdy(10, lat);
    check("wr_lat", lat, 32'd2);
    @(negedge clk);
    issue(1'b0, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0);
    wait_rdy(10, lat);
    check("rd_lat", lat, 32'd3);

    // m1 ALU read: leaves "last" = m1
    @(negedge clk);
    alu_val = 16'h00FF;
    base = mem_en_cnt;
    cnt  = alu_en_cnt;
    issue(1'b1, 1'b0, 16'h8002, 16'h0000, 16'h00FF, 1'b0);
    @(negedge clk);
    check("alu_en_addr", {28'd0, alu_en, alu_addr}, {28'd0, 1'b1, 3'd2});
    wait_rdy(10, lat);
    check("alu_lat", lat, 32'd2);
    check("alu_one_strobe", alu_en_cnt - cnt, 32'd1);
    check("alu_no_mem_en", mem_en_cnt - base, 32'd0);

    // Repeated contention: grant alternates m0, m1, m0, m1
    @(negedge clk);
    issue(1'b0, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0);
    issue(1'b1, 1'b1, 16'h0020, 16'h5555, 16'h0000, 1'b0);
    wait_rdy(10, lat);
    check("tie1_lat", lat, 32'd3);
    t0 = $time;
    @(negedge clk);
    issue(1'b0, 1'b1, 16'h0030, 16'h6666, 16'h0000, 1'b0);
    wait_rdy(10, lat);
    check("tie2_gap", 32'(($time - t0) / 10), 32'd4);
    t0 = $time;
    @(negedge clk);
    issue(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0);
    wait_rdy(10, lat);
    check("tie3_gap", 32'(($time - t0) / 10), 32'd4);
    t0 = $time;
    wait_rdy(10, lat);
    check("tie4_gap", 32'(($time - t0) / 10), 32'd4);

    // ext_ack while idle is ignored
    @(negedge clk);
    ext_ack = 1'b1;
    @(negedge clk);
    ext_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_ignored", {29'd0, m0_rdy, m1_rdy, |grant}, 32'd0);

    // EXT read, ack in cycle 10
    issue(1'b0, 1'b0, 16'h4000, 16'h0000, 16'hBEEF, 1'b0);
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ext_req) cnt++;
      if (i == 10) begin
        ext_ack   = 1'b1;
        ext_rdata = 16'hBEEF;
      end
    end
    check("ext_req_cycles", cnt, 32'd10);
    check("ext_addr", {16'd0, ext_addr}, 32'h4000);
    wait_rdy(5, lat);
    ext_ack = 1'b0;
    check("ext_lat", lat, 32'd1);
    check("ext_req_dropped", {31'd0, ext_req}, 32'd0);

`ifdef OISC_ARB_TIMEOUT_EN
    // No ack: aborted after 8 ext_req cycles with err
    @(negedge clk);
    issue(1'b1, 1'b1, 16'h4001, 16'h1111, 16'hFFFF, 1'b1);
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ext_req) cnt++;
    end
    check("tmo_req_cycles", cnt, 32'd8);
    wait_rdy(5, lat);
    check("tmo_lat", lat, 32'd1);
    check("tmo_req_dropped", {31'd0, ext_req}, 32'd0);
`endif

    // Reset during WAIT drops the transaction
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h4002;
    repeat (3) @(negedge clk);
    check("wait_ext_req", {31'd0, ext_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_ext_req", {30'd0, ext_req, |grant}, 32'd0);
    m0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m0_rdy || m1_rdy) cnt++;
    end
    check("no_rdy_after_rst", cnt, 32'd0);

    check("sb_empty", sb.size(), 32'd0);
    check("one_target", multi_cnt, 32'd0);
    check("no_consec_strobe", consec_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oisc_bus_arbiter.md
# oisc_bus_arbiter

Two-master bus arbiter and access sequencer for the OISC subsystem. It shares the 1K-word data memory, the memory-mapped ALU and the external port between the OISC core (master 0) and a host/debug loader (master 1). It decodes each access, sequences the target's strobes, and returns data with a one-cycle ready pulse. It replaces the per-target `~clk` ready wiring with a single clk-synchronous handshake.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: cycles allowed for an ext_ack before the access is aborted (used only with the macro).
- MEM_AW, 10: memory word-address width.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset: asynchronous, active-high.
- m0_req / m1_req  in  1  access request; held high until rdy is sampled.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  16  word address.
- m0_wdata / m1_wdata  in  16  write data.
- m0_rdata / m1_rdata  out  16  read data; valid while the matching rdy is high.
- m0_rdy / m1_rdy  out  1  one-cycle completion pulse.
- mem_en, mem_we  out  1  memory strobe and write enable.
- mem_addr  out  MEM_AW  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  synchronous read data, valid the cycle after mem_en.
- alu_en, alu_we  out  1  ALU strobe and write enable.
- alu_addr  out  3  ALU register select.
- alu_wdata  out  16  ALU write data.
- alu_rdata  in  16  synchronous, valid the cycle after alu_en.
- ext_req, ext_we  out  1  external request (level) and write enable.
- ext_addr, ext_wdata  out  16  external address and write data.
- ext_rdata  in  16  external read data, sampled with ext_ack.
- ext_ack  in  1  external completion, one cycle.
- grant  out  2  one-hot current owner; 0 when idle.
- err  out  1  timeout pulse, coincident with rdy.

## Operation
Address decode:
- MEM: addr[15:10] == 0.
- ALU: addr[15] == 1 and addr[14:3] == 0.
- EXT: every other address.

State machine:
- IDLE -> ACCESS on any req. The grant is chosen, and the master's we, addr and wdata are latched.
- ACCESS
  - MEM/ALU: en asserted for exactly this cycle, with the latched we, addr and wdata; -> CAPTURE.
  - EXT: ext_req raised; -> WAIT.
- WAIT: ext_req held high. On ext_ack, ext_rdata is captured and ext_req drops that cycle; -> RESP.
- CAPTURE: target rdata registered into the response register; -> RESP.
- RESP: the granted master's rdy = 1 and rdata = the response register; grant then clears; -> IDLE.

Response data and priority:
- Writes return rdata = 16'h0000.
- The non-granted master's rdy stays 0, and its rdata holds its last value.
- Arbitration is round-robin. When both masters request in IDLE, the master not served last wins. After reset, "last" = m1, so m0 wins the first tie.
- A lone request is granted immediately, whatever "last" holds.

Handshake:
- A master drops req on the edge where it samples rdy = 1.
- A master may re-raise req on the next cycle. Back-to-back accesses from one master are legal.
- A pending req from the other master is served next, because of round-robin.

Reset:
- All outputs reset to 0, state to IDLE, and "last" to m1.
- A reset mid-transaction drops the transaction with no rdy. ext_req falls asynchronously.

## Timing
- MEM/ALU: req seen in cycle 0 (IDLE), en in cycle 1, capture in cycle 2, rdy in cycle 3. Latency is 3 cycles; throughput is one access per 4 cycles.
- EXT: if ack arrives in cycle k (k ≥ 2), rdy occurs in cycle k+1.
- Contention: if both masters request in cycle 0, the loser's rdy occurs in cycle 7, at the earliest.
- Target strobes (en) are never asserted in two consecutive cycles.
- Only one target is active at any time.
- ext_ack outside WAIT is ignored.
- Changes to req, addr or wdata after the grant are ignored until the next IDLE.

## Configuration
Macro OISC_ARB_TIMEOUT_EN.

Defined:
- A counter in WAIT counts cycles.
- After TIMEOUT_CYCLES cycles without ack, ext_req drops, rdata = 16'hFFFF, and err pulses together with rdy.
- If ack arrives in the same cycle as expiry, ack wins and err stays 0.

Undefined:
- WAIT never exits without ack.
- err is tied to 0.
- No counter logic is built.

## Structure
Shared package oisc_bus_pkg:
- MEM_REGION_MASK, ALU_BASE = 16'h8000, ALU_SPAN = 8.
- Region enum {REG_MEM, REG_ALU, REG_EXT}.
- State enum {IDLE, ACCESS, WAIT, CAPTURE, RESP}.

Sub-module oisc_addr_decode: combinational 16-bit address to region enum. It is reused by the core testbench and any future bus bridge.

## Test plan
- Reset with m0_req = 1 held: all outputs 0. After rst falls, mem_en fires in cycle 1 and m0_rdy in cycle 3.
- m0 writes 16'h1234 to 0x0005, then reads 0x0005 -> mem_we = 1 with mem_addr = 5; the read returns m0_rdata = 16'h1234 with rdy 3 cycles after req.
- m0 and m1 both request in the same cycle, repeatedly -> grant alternates m0, m1, m0. rdy pulses are 4 cycles apart, and neither master is starved.
- m1 reads 0x8002 with the ALU returning 16'h00FF -> alu_addr = 2, alu_en for one cycle, mem_en never asserted, m1_rdata = 16'h00FF.
- EXT read of 0x4000 with ext_ack after 10 cycles and ext_rdata = 16'hBEEF -> ext_req high for 10 cycles; rdy occurs the cycle after ack, with data 16'hBEEF.
- With OISC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no ack -> ext_req drops after 8 cycles; rdata = 16'hFFFF with err = 1. Asserting rst during WAIT instead -> no rdy, and ext_req is 0 immediately.
